// File: rtl/clock_divider_pkg.sv
// Shared defaults and the half-period helper for the LED clock divider.
package clock_divider_pkg;

  localparam int DEF_CLK_HZ = 32'sd10000;
  localparam int DEF_LED_HZ = 32'sd1;

  function automatic int half_count(input int clk_hz, input int led_hz);
    return clk_hz / (32'sd2 * led_hz);
  endfunction

endpackage

// File: rtl/clkdiv_counter.sv
// Mod-N counter with synchronous reset and enable; wrap_o flags the enabled
// cycle on which the count sits at N-1, i.e. the edge that returns it to 0.
module clkdiv_counter #(
  parameter int N = 5000,
  parameter int W = $clog2(N)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic wrap_o
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count and wrap detection
  always_comb begin
    cnt_d  = cnt_q;
    wrap_o = 1'b0;
    if (en_i) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        wrap_o = 1'b1;
      end else begin
        cnt_d  = cnt_q + W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clock_divider_led.sv
// Divides clk to a 50% duty LED square wave plus a one-cycle tick per LED edge.
// Optional enable input: define CLOCK_DIVIDER_LED_ENABLE_EN.
module clock_divider_led
  import clock_divider_pkg::*;
#(
  parameter int CLK_HZ = DEF_CLK_HZ,
  parameter int LED_HZ = DEF_LED_HZ
) (
  input  logic clk,
  input  logic rst,
`ifdef CLOCK_DIVIDER_LED_ENABLE_EN
  input  logic en,
`endif
  output logic LED,
  output logic tick
);

  localparam int HALF_CNT = half_count(CLK_HZ, LED_HZ);
  localparam int CNT_W    = (HALF_CNT > 1) ? $clog2(HALF_CNT) : 1;

  generate
    if (HALF_CNT < 2) begin : g_bad_ratio
      $error("clock_divider_led: HALF_CNT must be >= 2");
    end
  endgenerate

  logic en_s;
  logic wrap_s;
  logic led_q;
  logic led_d;
  logic tick_q;
  logic tick_d;

`ifdef CLOCK_DIVIDER_LED_ENABLE_EN
  assign en_s = en;
`else
  assign en_s = 1'b1;
`endif

  clkdiv_counter #(
    .N (HALF_CNT),
    .W (CNT_W)
  ) u_counter (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (en_s),
    .wrap_o (wrap_s)
  );

  // LED toggles and tick fires on the wrap edge only
  always_comb begin
    led_d  = led_q ^ wrap_s;
    tick_d = wrap_s;
  end

  // Output flops; reset beats a coincident wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      led_q  <= led_d;
      tick_q <= tick_d;
    end
  end

  assign LED  = led_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_clock_divider_led.sv
// Self-checking bench: default divider (HALF_CNT=5000) and a small one (HALF_CNT=4)
// share stimulus and are checked every cycle against an enabled-edge-count model.
module tb_clock_divider_led;

  localparam int HALF_BIG   = 5000;
  localparam int HALF_SMALL = 4;

  logic clk = 1'b0;
  logic rst_s;
  logic en_s;
  logic led_big, tick_big, led_small, tick_small;

  int checks;
  int errors;

  // Model state: enabled non-reset edges since the last reset edge
  int   since_q = 0;
  logic valid_q = 1'b0;
  logic tick_big_exp_q = 1'b0;
  logic tick_small_exp_q = 1'b0;

  always #5 clk = ~clk;

  clock_divider_led dut_big (
    .clk  (clk),
    .rst  (rst_s),
`ifdef CLOCK_DIVIDER_LED_ENABLE_EN
    .en   (en_s),
`endif
    .LED  (led_big),
    .tick (tick_big)
  );

  clock_divider_led #(
    .CLK_HZ (8),
    .LED_HZ (1)
  ) dut_small (
    .clk  (clk),
    .rst  (rst_s),
`ifdef CLOCK_DIVIDER_LED_ENABLE_EN
    .en   (en_s),
`endif
    .LED  (led_small),
    .tick (tick_small)
  );

  always @(posedge clk) begin
    if (rst_s) begin
      since_q          <= 0;
      valid_q          <= 1'b1;
      tick_big_exp_q   <= 1'b0;
      tick_small_exp_q <= 1'b0;
    end else if (en_s) begin
      since_q          <= since_q + 1;
      tick_big_exp_q   <= ((since_q + 1) % HALF_BIG) == 0;
      tick_small_exp_q <= ((since_q + 1) % HALF_SMALL) == 0;
    end else begin
      tick_big_exp_q   <= 1'b0;
      tick_small_exp_q <= 1'b0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock and compare both DUTs against the model
  task automatic step();
    @(negedge clk);
    if (valid_q) begin
      check("led_big",    led_big,    (since_q / HALF_BIG) % 2);
      check("tick_big",   tick_big,   tick_big_exp_q);
      check("led_small",  led_small,  (since_q / HALF_SMALL) % 2);
      check("tick_small", tick_small, tick_small_exp_q);
    end
  endtask

  initial begin
    int pat [8] = '{0, 0, 0, 1, 1, 1, 1, 0};
    int edge_at [4] = '{0, 0, 0, 0};
    int edges;
    int ticks;
    int n;
    logic prev;

    checks = 0;
    errors = 0;
    rst_s  = 1'b1;
    en_s   = 1'b1;

    repeat (3) step();
    check("reset_led", led_big, 0);
    check("reset_tick", tick_big, 0);
    rst_s = 1'b0;

    for (int k = 0; k < 8; k++) begin
      step();
      check("small_pattern", led_small, pat[k]);
    end

    edges = 0;
    ticks = 0;
    prev  = led_big;
    for (int c = 9; c <= 20000; c++) begin
      step();
      if (led_big != prev) begin
        if (edges < 4) edge_at[edges] = c;
        edges++;
      end
      if (tick_big) ticks++;
      prev = led_big;
    end
    check("edge_count", edges, 4);
    check("tick_count", ticks, 4);
    for (int j = 0; j < 4; j++) begin
      check("edge_cycle", edge_at[j], HALF_BIG * (j + 1));
    end

    for (int p = 0; p < 6; p++) begin
      n    = 0;
      prev = led_big;
      do begin
        step();
        n++;
      end while (led_big == prev && n < 6000);
      check("phase_len", n, 5000);
    end

    rst_s = 1'b1;
    step();
    rst_s = 1'b0;
    repeat (7500) step();
    check("led_at_7500", led_big, 1);
    rst_s = 1'b1;
    step();
    check("mid_rst_led", led_big, 0);
    check("mid_rst_tick", tick_big, 0);
    rst_s = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (led_big == 1'b0 && n < 6000);
    check("rise_after_rst", n, 5000);

`ifdef CLOCK_DIVIDER_LED_ENABLE_EN
    repeat (1000) step();
    en_s  = 1'b0;
    ticks = 0;
    for (int c = 0; c < 1000; c++) begin
      step();
      if (tick_big) ticks++;
    end
    check("frozen_led", led_big, 1);
    check("frozen_ticks", ticks, 0);
    en_s = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (led_big == 1'b1 && n < 6000);
    check("delayed_fall", n, 4000);
`endif

    for (int c = 0; c < 5000; c++) begin
      rst_s = ($urandom_range(0, 99) == 0);
`ifdef CLOCK_DIVIDER_LED_ENABLE_EN
      en_s = ($urandom_range(0, 9) != 0);
`endif
      step();
    end
    rst_s = 1'b0;
    en_s  = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
